// File: rtl/aegnn_pkg.sv
// Shared types for the AEGNN event path: event payload and FC output width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package aegnn_pkg;

    localparam int FC_OUT_WIDTH = 16;

    typedef struct packed {
        logic [15:0] ts;
        logic [7:0]  x;
        logic [7:0]  y;
        logic        pol;
    } event_s;

endpackage

// File: rtl/aegnn_event_dispatch.sv
// Event dispatcher in front of the AEGNN core. It buffers host events, runs them one at a time
//   through the ip_en/ip_clean handshake and returns each prediction as a one-entry result stream.
// Latency: event at FIFO head, core idle, result slot empty -> ip_en two cycles later.
// Backpressure: s_evt_ready drops when the FIFO is full or a clean is running; an unread result
//   blocks further dispatch, so events wait in the FIFO.
// Ports: host event stream (s_evt_*), clean_req/clean_done, core control (ip_*), current event
//   (new_event), core results in (prediction, fc_out_pack), result stream (m_res_*), sticky
//   err_timeout, and perf_last_lat/perf_max_lat.
// Optional feature macro: DISPATCH_PERF_EN adds the run-latency counters; without it the perf
//   outputs are tied to zero.
module aegnn_event_dispatch
    import aegnn_pkg::*;
#(
    parameter int EVT_FIFO_DEPTH = 16,
    parameter int FC_OUT_C       = 2,
    parameter int SEQ_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             s_evt_valid,
    output logic                             s_evt_ready,
    input  event_s                           s_evt_data,
    input  logic                             clean_req,
    output logic                             clean_done,
    output logic                             ip_en,
    output logic                             ip_clean,
    input  logic                             ip_idle,
    input  logic                             ip_done,
    input  logic                             ip_clear,
    output event_s                           new_event,
    input  logic                             prediction,
    input  logic [FC_OUT_C*FC_OUT_WIDTH-1:0] fc_out_pack,
    output logic                             m_res_valid,
    input  logic                             m_res_ready,
    output logic                             m_res_pred,
    output logic [FC_OUT_C*FC_OUT_WIDTH-1:0] m_res_fc,
    output logic [SEQ_WIDTH-1:0]             m_res_seq,
    output logic                             err_timeout,
    output logic [31:0]                      perf_last_lat,
    output logic [31:0]                      perf_max_lat
);

    localparam int FC_W = FC_OUT_C * FC_OUT_WIDTH;
    localparam int AW   = $clog2(EVT_FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_CAPTURE,
        ST_RELEASE,
        ST_CLEAN,
        ST_CLEAN_REL
    } state_e;

    state_e               state_q, state_d;
    logic                 clean_pending_q, clean_pending_d;
    logic [SEQ_WIDTH-1:0] seq_q, seq_d;
    event_s               new_event_q, new_event_d;
    logic                 m_res_valid_q, m_res_valid_d;
    logic                 m_res_pred_q, m_res_pred_d;
    logic [FC_W-1:0]      m_res_fc_q, m_res_fc_d;
    logic [SEQ_WIDTH-1:0] m_res_seq_q, m_res_seq_d;
    logic                 err_timeout_q, err_timeout_d;
    logic [31:0]          run_cnt_q, run_cnt_d;
    logic                 clean_done_q, clean_done_d;

    // Event FIFO: pointers carry one extra wrap bit to tell full from empty.
    event_s               fifo_mem_q [EVT_FIFO_DEPTH];
    logic [AW:0]          wr_ptr_q, wr_ptr_d;
    logic [AW:0]          rd_ptr_q, rd_ptr_d;
    logic                 fifo_empty;
    logic                 fifo_full;
    event_s               fifo_head;

    logic                 evt_push;
    logic                 start_clean;
    logic                 start_load;
    logic                 in_clean;
    logic                 clean_finish;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign fifo_head  = fifo_mem_q[rd_ptr_q[AW-1:0]];

    assign in_clean    = (state_q == ST_CLEAN) || (state_q == ST_CLEAN_REL);
    // Gated by rstn so the host sees ready=0 while reset is held.
    assign s_evt_ready = rstn && !fifo_full && !in_clean;
    assign evt_push    = s_evt_valid && s_evt_ready;

    // A pending clean wins over queued events; dispatch also needs an empty result slot.
    assign start_clean  = (state_q == ST_IDLE) && clean_pending_q && ip_idle;
    assign start_load   = (state_q == ST_IDLE) && !clean_pending_q && ip_idle &&
                          !fifo_empty && !m_res_valid_q;
    assign clean_finish = (state_q == ST_CLEAN_REL) && ip_idle;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (start_clean) begin
            // Flush on clean entry; a push landing on the same edge is discarded with the rest.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (evt_push) begin
                wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            end
            if (start_load) begin
                rd_ptr_d = rd_ptr_q + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (evt_push) begin
            fifo_mem_q[wr_ptr_q[AW-1:0]] <= s_evt_data;
        end
    end

    always_comb begin
        state_d         = state_q;
        clean_pending_d = clean_pending_q | clean_req;
        seq_d           = seq_q;
        new_event_d     = new_event_q;
        m_res_valid_d   = m_res_valid_q;
        m_res_pred_d    = m_res_pred_q;
        m_res_fc_d      = m_res_fc_q;
        m_res_seq_d     = m_res_seq_q;
        err_timeout_d   = err_timeout_q;
        run_cnt_d       = run_cnt_q;
        clean_done_d    = 1'b0;

        if (m_res_valid_q && m_res_ready) begin
            m_res_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_clean) begin
                    state_d = ST_CLEAN;
                end else if (start_load) begin
                    state_d     = ST_LOAD;
                    new_event_d = fifo_head;
                end
            end
            ST_LOAD: begin
                state_d   = ST_RUN;
                run_cnt_d = '0;
            end
            ST_RUN: begin
                run_cnt_d = (run_cnt_q == '1) ? run_cnt_q : run_cnt_q + 32'd1;
                if ((TIMEOUT_CYCLES != 0) && (run_cnt_q == 32'(TIMEOUT_CYCLES - 1))) begin
                    err_timeout_d = 1'b1;
                end
                if (ip_done) begin
                    state_d = ST_CAPTURE;
                    // Core outputs are sampled on the ip_done edge, where they are known valid;
                    // the slot is empty here, so updating the data lines early is invisible.
                    m_res_pred_d = prediction;
                    m_res_fc_d   = fc_out_pack;
                end
            end
            ST_CAPTURE: begin
                state_d       = ST_RELEASE;
                m_res_valid_d = 1'b1;
                m_res_seq_d   = seq_q;
                seq_d         = seq_q + SEQ_WIDTH'(1);
            end
            ST_RELEASE: begin
                if (ip_idle) begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAN: begin
                if (ip_clear) begin
                    state_d = ST_CLEAN_REL;
                end
            end
            ST_CLEAN_REL: begin
                if (ip_idle) begin
                    state_d         = ST_IDLE;
                    clean_done_d    = 1'b1;
                    // A request arriving on the finishing cycle starts a fresh clean.
                    clean_pending_d = clean_req;
                    seq_d           = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q         <= ST_IDLE;
            clean_pending_q <= 1'b0;
            seq_q           <= '0;
            new_event_q     <= '0;
            m_res_valid_q   <= 1'b0;
            m_res_pred_q    <= 1'b0;
            m_res_fc_q      <= '0;
            m_res_seq_q     <= '0;
            err_timeout_q   <= 1'b0;
            run_cnt_q       <= '0;
            clean_done_q    <= 1'b0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
        end else begin
            state_q         <= state_d;
            clean_pending_q <= clean_pending_d;
            seq_q           <= seq_d;
            new_event_q     <= new_event_d;
            m_res_valid_q   <= m_res_valid_d;
            m_res_pred_q    <= m_res_pred_d;
            m_res_fc_q      <= m_res_fc_d;
            m_res_seq_q     <= m_res_seq_d;
            err_timeout_q   <= err_timeout_d;
            run_cnt_q       <= run_cnt_d;
            clean_done_q    <= clean_done_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
        end
    end

    assign ip_en       = (state_q == ST_RUN);
    assign ip_clean    = (state_q == ST_CLEAN);
    assign new_event   = new_event_q;
    assign m_res_valid = m_res_valid_q;
    assign m_res_pred  = m_res_pred_q;
    assign m_res_fc    = m_res_fc_q;
    assign m_res_seq   = m_res_seq_q;
    assign err_timeout = err_timeout_q;
    assign clean_done  = clean_done_q;

`ifdef DISPATCH_PERF_EN
    logic [31:0] perf_last_q, perf_last_d;
    logic [31:0] perf_max_q, perf_max_d;

    // run_cnt_q holds the number of cycles since ip_en rose, saturating at all-ones.
    always_comb begin
        perf_last_d = perf_last_q;
        perf_max_d  = perf_max_q;
        if ((state_q == ST_RUN) && ip_done) begin
            perf_last_d = run_cnt_q;
            if (run_cnt_q > perf_max_q) begin
                perf_max_d = run_cnt_q;
            end
        end
        if (clean_finish) begin
            perf_last_d = '0;
            perf_max_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            perf_last_q <= '0;
            perf_max_q  <= '0;
        end else begin
            perf_last_q <= perf_last_d;
            perf_max_q  <= perf_max_d;
        end
    end

    assign perf_last_lat = perf_last_q;
    assign perf_max_lat  = perf_max_q;
`else
    assign perf_last_lat = '0;
    assign perf_max_lat  = '0;
`endif

endmodule
